bit_serial_addsub: RTL and testbench

- Sequencing controller that time-multiplexes one fullAdder cell to perform a WIDTH-bit add or subtract, one bit per clock, LSB first.
- Used where area matters more than latency, as a serial alternative to ripple chains of fullAdder instances.
- Operands enter through a valid/ready handshake. The result leaves through a second valid/ready handshake and is held until the consumer takes it.

---
 rtl/bit_serial_addsub.sv | 130 +++++++++++++
 tb/tb_bit_serial_addsub.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_addsub.sv
// Bit-serial adder/subtractor. A single full-adder cell is reused once per
// clock, LSB first, to produce a WIDTH-bit sum (or difference) and carry-out.
// Optional signed-overflow output: define ADDSUB_OVF_EN.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for an operand bundle; in_ready=1
// RUN   | one bit per clock through the full adder; WIDTH cycles
// DONE  | result held on sum/cout(/ovf); out_valid=1 until out_ready

module fullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module bit_serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADDSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  sh_a, sh_b;
  logic              carry;
  logic [CNT_W-1:0]  cnt;
  logic              fa_s, fa_c;
  logic              accept, last_bit;

  fullAdder u_fa (
    .a    (sh_a[0]),
    .b    (sh_b[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    last_bit  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt == CNT_W'(WIDTH - 1)) begin
          last_bit = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, serial shift datapath and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_a  <= '0;
      sh_b  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef ADDSUB_OVF_EN
      ovf   <= 1'b0;
`endif
    end else if (accept) begin
      // Subtraction is A + ~B + 1: invert B and seed the carry with sub.
      sh_a  <= a;
      sh_b  <= sub ? ~b : b;
      carry <= sub;
      cnt   <= '0;
    end else if (state_q == RUN) begin
      sum   <= {fa_s, sum[WIDTH-1:1]};
      sh_a  <= sh_a >> 1;
      sh_b  <= sh_b >> 1;
      carry <= fa_c;
      cnt   <= cnt + CNT_W'(1);
      if (last_bit) begin
        cout <= fa_c;
`ifdef ADDSUB_OVF_EN
        // carry still holds the carry into the MSB on this edge.
        ovf  <= carry ^ fa_c;
`endif
      end
    end
  end

endmodule

// File: tb/tb_bit_serial_addsub.sv
// Scoreboard bench for bit_serial_addsub (WIDTH=8). Stimulus pushes the
// expected result when it issues an operation; a forked monitor pops and
// compares on every output handshake.

module tb_bit_serial_addsub;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf_dut;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  bit_serial_addsub #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef ADDSUB_OVF_EN
    ,
    .ovf       (ovf_dut)
`endif
  );

`ifndef ADDSUB_OVF_EN
  assign ovf_dut = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'(sum), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("sum", 32'(sum), 32'(e.sum));
          chk("cout", 32'(cout), 32'(e.cout));
`ifdef ADDSUB_OVF_EN
          chk("ovf", 32'(ovf_dut), 32'(e.ovf));
`endif
        end
      end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50; i++) begin
      if (in_ready) return;
      @(posedge clk); #1;
    end
    chk("idle_timeout", 32'(in_ready), 32'd1);
  endtask

  // Issue one op, check latency and in_ready during RUN; returns in DONE.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts,
                        input logic [W-1:0] es, input logic ec, input logic eo,
                        input bit junk);
    exp_t e;
    wait_idle();
    e.sum = es; e.cout = ec; e.ovf = eo;
    exp_q.push_back(e);
    a = ta; b = tb_; sub = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    if (junk) begin
      a = 8'hAA; b = 8'hAA; sub = 1'b1; in_valid = 1'b1;
    end else begin
      in_valid = 1'b0;
    end
    for (int k = 1; k <= W; k++) begin
      if (k < W) chk("in_ready_run", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      if (k < W) chk("out_valid_early", 32'(out_valid), 32'd0);
      else       chk("out_valid_latency", 32'(out_valid), 32'd1);
    end
  endtask

  initial begin
    int t0, t1, tv;
    fork monitor(); join_none

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf_dut), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic add, then hand-off returns to IDLE the next cycle.
    run_op(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("in_ready_after_handoff", 32'(in_ready), 32'd1);

    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    run_op(8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);

    // Backpressure with in-flight junk operands.
    wait_idle();
    out_ready = 1'b0;
    run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_sum", 32'(sum), 32'h46);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_in_ready", 32'(in_ready), 32'd1);
    chk("bp_out_valid_drop", 32'(out_valid), 32'd0);

    // Reset three cycles into RUN discards the operation.
    a = 8'h10; b = 8'h20; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_cout", 32'(cout), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);

    // Back-to-back with in_valid held high.
    wait_idle();
    begin
      exp_t e1, e2;
      e1.sum = 8'h08; e1.cout = 1'b0; e1.ovf = 1'b0;
      e2.sum = 8'h0A; e2.cout = 1'b0; e2.ovf = 1'b0;
      exp_q.push_back(e1);
      exp_q.push_back(e2);
    end
    a = 8'h05; b = 8'h03; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    t0 = cyc; t1 = -1; tv = -1;
    a = 8'h05; b = 8'h05;
    for (int i = 0; i < 30; i++) begin
      if (in_ready) begin
        @(posedge clk); #1;
        t1 = cyc;
        break;
      end
      @(posedge clk); #1;
      if (out_valid && tv < 0) tv = cyc;
    end
    in_valid = 1'b0;
    chk("b2b_first_latency", 32'(tv - t0), 32'(W));
    chk("b2b_accept_spacing", 32'(t1 - t0), 32'(W + 2));
    for (int k = 1; k <= W; k++) begin
      @(posedge clk); #1;
      if (k == W) chk("b2b_second_latency", 32'(out_valid), 32'd1);
    end

    // Drain the scoreboard.
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
